// File: rtl/sample_prefetcher.sv
// sample_prefetcher: issues generate_next requests to a sample producer, buffers the
// returned samples in a FIFO and serves them to the codec side on next_sample.
//
// state  | meaning
// IDLE   | no request outstanding; waits for enable and FIFO space
// REQ    | one-cycle generate_next pulse, wait counter cleared
// WAIT   | request outstanding; counting toward TIMEOUT
module sample_prefetcher #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic                   generate_next,
  input  logic                   sample_ready,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   next_sample,
  output logic [WIDTH-1:0]       sample_out,
  output logic                   sample_valid,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   underflow,
  output logic                   timeout_err,
  input  logic                   clear_flags
);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(TIMEOUT);
  localparam int TO_LAST_I = TIMEOUT - 1;
  localparam int DEPTH_I   = DEPTH;
  localparam logic [CW-1:0] TO_LAST  = TO_LAST_I[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [AW:0]   FULL     = DEPTH_I[AW:0];
  localparam logic [AW:0]   FILL_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill_nxt;
  logic              wr_en, rd_en, timeout_hit, read_empty;

  assign wr_en       = (state == S_WAIT) && sample_ready;
  assign rd_en       = next_sample && (fill_level != '0);
  assign read_empty  = next_sample && (fill_level == '0);
  assign timeout_hit = (state == S_WAIT) && !sample_ready && (wait_cnt == TO_LAST);

  always_comb begin
    fill_nxt = fill_level;
    if (wr_en && !rd_en)      fill_nxt = fill_level + FILL_ONE;
    else if (!wr_en && rd_en) fill_nxt = fill_level - FILL_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Re-issue straight from WAIT uses the post-capture occupancy.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable && (fill_level != FULL)) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (wr_en)            state_nxt = (enable && (fill_nxt != FULL)) ? S_REQ : S_IDLE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    generate_next = 1'b0;
    if (state == S_REQ) generate_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      fill_level   <= fill_nxt;
      sample_valid <= next_sample;
      if (rd_en)            sample_out <= mem[rd_ptr];
      else if (next_sample) sample_out <= '0;
      // Set events take priority over a simultaneous clear.
      if (read_empty)       underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
      if (timeout_hit)      timeout_err <= 1'b1;
      else if (clear_flags) timeout_err <= 1'b0;
      if (state == S_REQ)       wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sample_prefetcher.sv
// Bench for sample_prefetcher: directed scenarios plus a random phase, all checked
// cycle by cycle against a queue-based reference of the request/FIFO behaviour.
module tb_sample_prefetcher;
  localparam int DEPTH = 8, WIDTH = 16, TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n, enable, generate_next, sample_ready, next_sample;
  logic sample_valid, underflow, timeout_err, clear_flags;
  logic [WIDTH-1:0] sample_in, sample_out;
  logic [3:0] fill_level;

  always #5 clk = ~clk;

  sample_prefetcher #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .generate_next(generate_next),
    .sample_ready(sample_ready), .sample_in(sample_in), .next_sample(next_sample),
    .sample_out(sample_out), .sample_valid(sample_valid), .fill_level(fill_level),
    .underflow(underflow), .timeout_err(timeout_err), .clear_flags(clear_flags)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  // reference: FIFO contents, last read value, flags, outstanding request
  logic [15:0] q[$];
  logic [15:0] m_out;
  bit m_valid, m_uf, m_to, m_pending;
  int m_gen;

  // producer
  bit prod_on, rand_data, rand_phase;
  int prod_lat, resp_at;
  logic [15:0] next_val;
  int gen_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out = '0; m_valid = 0; m_uf = 0; m_to = 0; m_pending = 0; m_gen = 0;
    resp_at = -1;
  endtask

  task automatic step();
    bit wr, rd, clr, to_set, uf_set;
    logic [15:0] din;
    wr     = reset_n && sample_ready && m_pending && (cyc > m_gen) && (cyc <= m_gen + TIMEOUT);
    rd     = reset_n && next_sample;
    clr    = clear_flags;
    din    = sample_in;
    to_set = reset_n && m_pending && !wr && (cyc == m_gen + TIMEOUT);
    @(posedge clk); #1; cyc++;
    if (!reset_n) model_reset();
    else begin
      uf_set  = 0;
      m_valid = rd;
      if (rd) begin
        if (q.size() > 0) m_out = q.pop_front();
        else begin m_out = '0; uf_set = 1; end
      end
      if (wr) begin q.push_back(din); m_pending = 0; end
      if (to_set) m_pending = 0;
      if (uf_set) m_uf = 1; else if (clr) m_uf = 0;
      if (to_set) m_to = 1; else if (clr) m_to = 0;
    end
    next_sample = 0; sample_ready = 0; clear_flags = 0;
    check("fill_level", 32'(fill_level), 32'(q.size()));
    check("sample_valid", 32'(sample_valid), 32'(m_valid));
    check("sample_out", 32'(sample_out), 32'(m_out));
    check("underflow", 32'(underflow), 32'(m_uf));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
    if (generate_next === 1'b1) begin
      check("gen_single_outstanding", 32'(m_pending), 32'(0));
      check("gen_has_space", 32'(q.size() < DEPTH), 32'(1));
      m_pending = 1; m_gen = cyc; gen_log.push_back(cyc);
      if (prod_on) resp_at = cyc + (rand_phase ? int'($urandom_range(1, 17)) : prod_lat);
    end
    if (reset_n && cyc == resp_at) begin
      sample_ready = 1;
      sample_in = rand_data ? 16'($urandom) : next_val;
      next_val++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_en, t_g, t2;
    bit found;
    logic [15:0] head, newv;
    reset_n = 0; enable = 0; sample_ready = 0; sample_in = '0; next_sample = 0; clear_flags = 0;
    prod_on = 0; prod_lat = 2; next_val = 16'd1; rand_data = 0; rand_phase = 0;
    model_reset();

    // reset state
    repeat (3) step();
    check("rst_generate_next", 32'(generate_next), 32'(0));
    reset_n = 1;
    repeat (2) step();

    // fill from reset with a 2-cycle producer
    prod_on = 1; enable = 1; t_en = cyc; gen_log.delete();
    repeat (40) step();
    check("fill_gen_count", 32'(gen_log.size()), 32'(8));
    check("fill_first_gen", 32'(gen_log[0]), 32'(t_en + 1));
    for (int i = 1; i < gen_log.size(); i++)
      check("fill_gen_spacing", 32'(gen_log[i] - gen_log[i-1]), 32'(3));
    check("fill_full", 32'(fill_level), 32'(8));

    // drain order
    enable = 0;
    for (int i = 0; i < 8; i++) begin
      next_sample = 1;
      step();
      check("drain_value", 32'(sample_out), 32'(i + 1));
      check("drain_valid", 32'(sample_valid), 32'(1));
    end
    step();
    check("drain_empty", 32'(fill_level), 32'(0));
    check("drain_hold", 32'(sample_out), 32'(8));

    // refill restarts
    enable = 1;
    step();
    check("refill_gen", 32'(generate_next), 32'(1));

    // simultaneous read and write at fill_level 4
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (q.size() == 4 && sample_ready) found = 1;
    end
    check("rw_reached", 32'(found), 32'(1));
    head = q[0]; newv = sample_in;
    next_sample = 1; enable = 0;
    step();
    check("rw_fill", 32'(fill_level), 32'(4));
    check("rw_pop_head", 32'(sample_out), 32'(head));
    for (int i = 0; i < 4; i++) begin next_sample = 1; step(); end
    check("rw_tail", 32'(sample_out), 32'(newv));
    repeat (2) step();

    // underflow
    next_sample = 1;
    step();
    check("uf_out_zero", 32'(sample_out), 32'(0));
    check("uf_valid", 32'(sample_valid), 32'(1));
    check("uf_set", 32'(underflow), 32'(1));
    repeat (3) step();
    check("uf_sticky", 32'(underflow), 32'(1));
    clear_flags = 1;
    step();
    check("uf_clear", 32'(underflow), 32'(0));
    next_sample = 1; clear_flags = 1;
    step();
    check("uf_set_wins", 32'(underflow), 32'(1));
    clear_flags = 1;
    step();

    // timeout with a silent producer
    prod_on = 0; enable = 1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (generate_next) found = 1;
    end
    check("to_gen_seen", 32'(found), 32'(1));
    t_g = cyc;
    while (cyc < t_g + TIMEOUT) step();
    check("to_not_yet", 32'(timeout_err), 32'(0));
    step();
    check("to_at_T16", 32'(cyc - t_g), 32'(16));
    check("to_set", 32'(timeout_err), 32'(1));
    step();
    check("to_regen", 32'(generate_next), 32'(1));
    t2 = cyc; enable = 0;
    while (cyc < t2 + TIMEOUT + 2) step();
    sample_ready = 1; sample_in = 16'h5A5A;
    step();
    check("late_ready_ignored", 32'(fill_level), 32'(0));

    // reset in the middle of WAIT
    prod_on = 1; enable = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (q.size() >= 3) found = 1;
    end
    check("pre_rst_filled", 32'(found), 32'(1));
    next_sample = 1;
    step();
    prod_on = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (generate_next && resp_at != cyc + prod_lat) found = 1;
    end
    check("pre_rst_gen", 32'(found), 32'(1));
    step();
    check("pre_rst_fill_nz", 32'(fill_level != 0), 32'(1));
    check("pre_rst_to", 32'(timeout_err), 32'(1));
    reset_n = 0; enable = 0;
    #1;
    model_reset();
    check("rst_gen", 32'(generate_next), 32'(0));
    check("rst_fill", 32'(fill_level), 32'(0));
    check("rst_out", 32'(sample_out), 32'(0));
    check("rst_valid", 32'(sample_valid), 32'(0));
    check("rst_uf", 32'(underflow), 32'(0));
    check("rst_to", 32'(timeout_err), 32'(0));
    step();
    reset_n = 1;
    step();
    sample_ready = 1; sample_in = 16'h1234;
    step();
    check("rst_late_ready_ignored", 32'(fill_level), 32'(0));
    step();

    // random traffic
    rand_phase = 1; rand_data = 1; prod_on = 1;
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 9) < 8);
      next_sample = ($urandom_range(0, 9) < 3);
      clear_flags = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
